// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- what downstream sees when nothing valid is at the head
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    // One buffered fetch: the address it came from and the word read there
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head read and a flush that
// empties it in one cycle. Push and pop may coincide when full.
module fetch_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 64,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    // Pointer and occupancy bookkeeping; flush outranks push and pop.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; an entry is only visible once count
        // covers it, so stale contents are never observed.
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, reads the combinational
// instruction memory, and buffers {pc, instr} pairs for decode behind a
// valid/ready handshake. A redirect flushes the buffer and reloads the PC.
// Optional feature: define FETCH_PERF_CNT_EN to add the bubble_count port,
// a saturating count of cycles with no valid instruction at the head.
// The entry struct is XLEN wide, so WIDTH is expected to equal XLEN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [WIDTH-1:0] out_pc,
    output logic [31:0]      bubble_count
`else
    output logic [WIDTH-1:0] out_pc
`endif
);

    logic [WIDTH-1:0] pc_q;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    assign imem_addr = pc_q;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A pop frees the slot the push needs, so a full queue still accepts.
    assign push      = ~redirect & (~full | pop);
    assign wr_entry  = '{pc: pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Fetch PC: redirect wins, otherwise advance only when the fetch is buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pc_q <= RESET_PC;
        else if (redirect) pc_q <= redirect_pc;
        else if (push)     pc_q <= pc_q + PC_STEP;
    end

    // Head presentation: NOP and zero PC whenever the head is not valid.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        out_instr = INSTR_NOP;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = head.instr;
            out_pc    = head.pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Bubble counter: one per cycle without a valid head, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 bubble_count <= '0;
        else if (!out_valid && bubble_count != '1) bubble_count <= bubble_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue: one row per clock cycle giving the
// inputs to drive and the head/PC state expected during that cycle.
module tb_fetch_queue;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_count;
`endif

    typedef struct {
        logic        redir;
        logic [31:0] redir_pc;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Instruction memory model: word depends only on its address.
    assign imem_rdata = imem_addr ^ KEY;

    fetch_queue #(
        .WIDTH    (32),
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
`ifdef FETCH_PERF_CNT_EN
        .out_pc       (out_pc),
        .bubble_count (bubble_count)
`else
        .out_pc       (out_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] rpc, input logic rdy,
                       input logic v, input logic [31:0] pc, input logic [31:0] addr);
        vec_t x;
        x.redir = r; x.redir_pc = rpc; x.ready = rdy;
        x.exp_valid = v; x.exp_pc = pc; x.exp_addr = addr;
        vecs.push_back(x);
    endtask

    task automatic check_reset_values(input string tag, input logic [31:0] exp_bubble);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_instr"}, out_instr, NOP);
        check({tag, "_pc"},    out_pc, 32'd0);
        check({tag, "_addr"},  imem_addr, RPC);
`ifdef FETCH_PERF_CNT_EN
        check({tag, "_bubble"}, bubble_count, exp_bubble);
`endif
    endtask

    initial begin
        logic [31:0] exp_bubble;

        // Stall from reset: fills four entries, fetch freezes at RESET_PC+16.
        add(0, 0, 0, 0, 0,     32'h100);
        add(0, 0, 0, 1, 32'h100, 32'h104);
        add(0, 0, 0, 1, 32'h100, 32'h108);
        add(0, 0, 0, 1, 32'h100, 32'h10C);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 32'h100, 32'h110);
        // Release: buffered entries drain in order while full, no gaps.
        add(0, 0, 1, 1, 32'h100, 32'h110);
        add(0, 0, 1, 1, 32'h104, 32'h114);
        add(0, 0, 1, 1, 32'h108, 32'h118);
        add(0, 0, 1, 1, 32'h10C, 32'h11C);
        add(0, 0, 1, 1, 32'h110, 32'h120);
        add(0, 0, 1, 1, 32'h114, 32'h124);
        // Redirect while full and handshaking: head discarded, one bubble.
        add(1, 32'h2000, 1, 1, 32'h118, 32'h128);
        add(0, 0, 1, 0, 0,        32'h2000);
        add(0, 0, 1, 1, 32'h2000, 32'h2004);
        // Redirect near the top of the address space: PC wraps to zero.
        add(1, 32'hFFFF_FFF8, 1, 1, 32'h2004, 32'h2008);
        add(0, 0, 1, 0, 0,            32'hFFFF_FFF8);
        add(0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        add(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0000_0000);
        // Misaligned redirect target: advances by 4 from the raw value.
        add(1, 32'h302, 1, 1, 32'h0, 32'h4);
        add(0, 0, 1, 0, 0,      32'h302);
        add(0, 0, 1, 1, 32'h302, 32'h306);

        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        #1;
        check_reset_values("reset", 32'd0);

        @(negedge clk);
        #2 rst = 1'b0;

        exp_bubble = 0;
        foreach (vecs[i]) begin
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].redir_pc;
            out_ready   = vecs[i].ready;
            #0;
            check($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_valid ? vecs[i].exp_pc : 32'd0);
            check($sformatf("v%0d_instr", i), out_instr,
                  vecs[i].exp_valid ? (vecs[i].exp_pc ^ KEY) : NOP);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
`ifdef FETCH_PERF_CNT_EN
            check($sformatf("v%0d_bubble", i), bubble_count, exp_bubble);
`endif
            if (!vecs[i].exp_valid) exp_bubble++;
            @(posedge clk);
            #1;
        end
        redirect = 1'b0;

        // Mid-stream reset between edges: outputs clear without a clock.
        #3 rst = 1'b1;
        #1;
        check_reset_values("async_rst", 32'd0);
        #2 rst = 1'b0;
        #1;
        check_reset_values("post_rst", 32'd0);
        @(posedge clk);
        #1;
        check("restart_valid", {31'd0, out_valid}, 32'd1);
        check("restart_pc",    out_pc, RPC);
        check("restart_instr", out_instr, RPC ^ KEY);
        check("restart_addr",  imem_addr, RPC + 32'd4);
`ifdef FETCH_PERF_CNT_EN
        check("restart_bubble", bubble_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
